if_fetch_unit: RTL



---
 rtl/if_fetch_unit_pkg.sv | 36 +++
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit_inst_buffer.sv | 61 ++++++
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: exception bundle, queue entry,
// fetch FSM encoding and the default boot address.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic ReservedInstruction;
        logic Syscall;
        logic Break;
        logic Eret;
        logic WrWrongAddressinMEM;
        logic RdWrongAddressinMEM;
        logic Overflow;
        logic Trap;
    } ExceptinPipeType;

    typedef struct packed {
        logic [31:0]     pc;
        logic [31:0]     instr;
        ExceptinPipeType except;
    } IfEntry_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2
    } FetchState_t;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of the I-cache request/response bus and the IF side of the IF/ID
// hand-off; master is the fetch unit, slave is the cache/decode environment.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            IC_Req;
    logic [31:0]     IC_Addr;
    logic            IC_Ack;
    logic            IC_RValid;
    logic [31:0]     IC_RData;
    logic            ID_Wr;
    logic            IF_Valid;
    logic [31:0]     IF_Instr;
    logic [31:0]     IF_PC;
    ExceptinPipeType IF_ExceptType;

    modport master (
        output IC_Req, IC_Addr, IF_Valid, IF_Instr, IF_PC, IF_ExceptType,
        input  IC_Ack, IC_RValid, IC_RData, ID_Wr
    );

    modport slave (
        input  IC_Req, IC_Addr, IF_Valid, IF_Instr, IF_PC, IF_ExceptType,
        output IC_Ack, IC_RValid, IC_RData, ID_Wr
    );

endinterface

// File: rtl/if_fetch_unit_inst_buffer.sv
// Two-entry fetch queue (module if_inst_buffer); slot 0 is always the head,
// and the head output reads as all-zero while the queue is empty.
module if_inst_buffer
    import if_fetch_unit_pkg::*;
(
    input  logic     clk,
    input  logic     resetn,
    input  logic     push_i,
    input  IfEntry_t push_data_i,
    input  logic     pop_i,
    input  logic     clear_i,
    output logic [1:0] count_o,
    output logic     head_valid_o,
    output IfEntry_t head_o
);

    IfEntry_t   slot_q [2];
    IfEntry_t   slot_d [2];
    logic [1:0] count_q, count_d;

    always_comb begin
        count_d   = count_q;
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        if (clear_i) begin
            count_d = 2'd0;
        end else begin
            if (pop_i && count_q != 2'd0) begin
                slot_d[0] = slot_q[1];
                count_d   = count_q - 2'd1;
            end
            // Pop is applied first, so push+pop on a full queue still fits.
            if (push_i && count_d != 2'd2) begin
                if (count_d == 2'd0) begin
                    slot_d[0] = push_data_i;
                end else begin
                    slot_d[1] = push_data_i;
                end
                count_d = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q[0] <= slot_d[0];
        slot_q[1] <= slot_d[1];
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_o       = (count_q != 2'd0) ? slot_q[0] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding I-cache requests,
// redirect/discard handling. Optional stall counter under IF_FETCH_PERF_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_Redirect,
    input  logic [31:0] IF_RedirectPC,
    if_fetch_unit_if.master bus
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] IF_StallCycles
`endif
);

    FetchState_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        errhold_q, errhold_d;

    logic        push;
    IfEntry_t    push_entry;
    logic        pop;
    logic [1:0]  count;
    logic        head_valid;
    IfEntry_t    head;

    if_inst_buffer u_buf (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .clear_i      (IF_Redirect),
        .count_o      (count),
        .head_valid_o (head_valid),
        .head_o       (head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            errhold_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            errhold_q <= errhold_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        errhold_d  = errhold_q;
        push       = 1'b0;
        push_entry = '0;

        if (discard_q && bus.IC_RValid) begin
            discard_d = 1'b0;
        end

        unique case (state_q)
            FETCH_IDLE: begin
                // In IDLE nothing is outstanding, so room means count < 2.
                if (count != 2'd2) begin
                    if (!pc_aligned(pc_q)) begin
                        if (!errhold_q) begin
                            push                              = 1'b1;
                            push_entry.pc                     = pc_q;
                            push_entry.except.WrongAddressinIF = 1'b1;
                            errhold_d                         = 1'b1;
                        end
                    end else if (!discard_q) begin
                        state_d = FETCH_REQ;
                    end
                end
            end
            FETCH_REQ: begin
                if (bus.IC_Ack) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (bus.IC_RValid) begin
                    push             = 1'b1;
                    push_entry.pc    = pc_q;
                    push_entry.instr = bus.IC_RData;
                    pc_d             = pc_q + 32'd4;
                    state_d          = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        // A request the cache has taken but not answered must be swallowed later.
        if (IF_Redirect) begin
            push      = 1'b0;
            pc_d      = IF_RedirectPC;
            errhold_d = 1'b0;
            state_d   = FETCH_IDLE;
            discard_d = ((state_q == FETCH_REQ)  && bus.IC_Ack)     ||
                        ((state_q == FETCH_WAIT) && !bus.IC_RValid) ||
                        (discard_q && !bus.IC_RValid);
        end
    end

    always_comb begin
        bus.IC_Req = (state_q == FETCH_REQ);
    end

    assign pop               = head_valid && bus.ID_Wr && !IF_Redirect;
    assign bus.IC_Addr       = pc_q;
    assign bus.IF_Valid      = head_valid;
    assign bus.IF_PC         = head.pc;
    assign bus.IF_Instr      = head.instr;
    assign bus.IF_ExceptType = head.except;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (!head_valid && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign IF_StallCycles = stall_q;
`endif

endmodule
